// File: rtl/imem_access_sched_pkg.sv
// Shared types and default constants for the instruction-memory access scheduler.
package imem_access_sched_pkg;

   typedef enum logic {
      StOpen   = 1'b0,
      StLocked = 1'b1
   } sched_state_e;

   localparam int unsigned PORTW_DEF        = 32;
   localparam int unsigned ADDRWIDTH_DEF    = 7;
   localparam int unsigned STARVE_LIMIT_DEF = 4;
   localparam int unsigned STARVE_CNT_W     = 8;

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating count of consecutive denied port-2 cycles; sat flags LIMIT reached.
module imem_starve_cnt
   import imem_access_sched_pkg::*;
#(
   parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

   assign sat = (cnt_q == STARVE_CNT_W'(LIMIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !sat) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_access_sched.sv
// Two-port arbiter in front of a single-port instruction memory (fetch vs. loader).
// Define IMEM_ACCESS_SCHED_STARVE_EN to compile in port-2 starvation promotion.
module imem_access_sched
   import imem_access_sched_pkg::*;
#(
   parameter int unsigned PORTW        = PORTW_DEF,
   parameter int unsigned ADDRWIDTH    = ADDRWIDTH_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_1_x,
   input  logic [ADDRWIDTH-1:0] addr_1,
   output logic                 busy_1,
   output logic                 rvalid_1,
   output logic [PORTW-1:0]     q_1,
   input  logic                 en_2_x,
   input  logic                 wr_2_x,
   input  logic [ADDRWIDTH-1:0] addr_2,
   input  logic [PORTW-1:0]     d_2,
   input  logic [PORTW-1:0]     bit_wr_2_x,
   input  logic                 lock_2,
   output logic                 busy_2,
   output logic                 rvalid_2,
   output logic [PORTW-1:0]     q_2,
   output logic                 en_x,
   output logic                 wr_x,
   output logic [ADDRWIDTH-1:0] addr,
   output logic [PORTW-1:0]     d,
   output logic [PORTW-1:0]     bit_wr_x,
   input  logic [PORTW-1:0]     q
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("STARVE_LIMIT out of range 1..255");
   end

   sched_state_e state_q;
   logic         rvalid_1_q, rvalid_2_q;
   logic         req_1, req_2, gnt_1, gnt_2, prio_2, locked;

   // Reset masks both requests so no grant can leak out while rst is high.
   assign req_1  = ~en_1_x & ~rst;
   assign req_2  = ~en_2_x & ~rst;
   assign locked = (state_q == StLocked);

`ifdef IMEM_ACCESS_SCHED_STARVE_EN
   logic starve_sat;

   imem_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk (clk),
      .rst (rst),
      .inc (req_2 & ~gnt_2),
      .clr (~req_2 | gnt_2),
      .sat (starve_sat)
   );

   assign prio_2 = locked | starve_sat;
`else
   assign prio_2 = locked;
`endif

   assign gnt_2 = req_2 & (~req_1 | prio_2);
   // A locked burst keeps port 1 out even in gaps where port 2 is idle.
   assign gnt_1 = req_1 & ~gnt_2 & ~locked;

   assign busy_1 = rst | (~en_1_x & ~gnt_1);
   assign busy_2 = rst | (~en_2_x & ~gnt_2);

   always_comb begin
      en_x     = 1'b1;
      wr_x     = 1'b1;
      bit_wr_x = '1;
      addr     = addr_1;
      if (gnt_1) begin
         en_x = 1'b0;
      end else if (gnt_2) begin
         en_x     = 1'b0;
         wr_x     = wr_2_x;
         bit_wr_x = bit_wr_2_x;
         addr     = addr_2;
      end
   end

   assign d        = d_2;
   assign q_1      = q;
   assign q_2      = q;
   assign rvalid_1 = rvalid_1_q;
   assign rvalid_2 = rvalid_2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StOpen;
         rvalid_1_q <= 1'b0;
         rvalid_2_q <= 1'b0;
      end else begin
         rvalid_1_q <= gnt_1;
         rvalid_2_q <= gnt_2 & wr_2_x;
         case (state_q)
            StOpen:   if (gnt_2 && lock_2) state_q <= StLocked;
            StLocked: if (!lock_2) state_q <= StOpen;
            default:  state_q <= StOpen;
         endcase
      end
   end

endmodule

// File: doc/imem_access_sched.md
IMEM_ACCESS_SCHED -- requirements
Module: imem_access_sched

Interface
REQ-001 Parameters SHALL be, one per line:
- PORTW, 32, instruction/data word width.
- ADDRWIDTH, 7, memory address width.
- STARVE_LIMIT, 4, maximum consecutive denied port-2 cycles, range 1..255.
REQ-002 Ports SHALL be, one per line; a suffix _x means active-low:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_1_x  in  1  port-1 (core fetch, read-only) request.
- addr_1  in  ADDRWIDTH  port-1 address.
- busy_1  out  1  port-1 request denied this cycle.
- rvalid_1  out  1  q_1 holds port-1 read data.
- q_1  out  PORTW  port-1 read data.
- en_2_x  in  1  port-2 (loader/debug) request.
- wr_2_x  in  1  port-2 write strobe.
- addr_2  in  ADDRWIDTH  port-2 address.
- d_2  in  PORTW  port-2 write data.
- bit_wr_2_x  in  PORTW  port-2 per-bit write mask.
- lock_2  in  1  port-2 burst-lock request.
- busy_2  out  1  port-2 request denied this cycle.
- rvalid_2  out  1  q_2 holds port-2 read data.
- q_2  out  PORTW  port-2 read data.
- en_x, wr_x  out  1 each  memory enable and write strobe.
- addr  out  ADDRWIDTH  memory address.
- d  out  PORTW  memory write data.
- bit_wr_x  out  PORTW  memory bit-write mask.
- q  in  PORTW  memory read data, valid 1 cycle after an enabled read.
REQ-003 The block SHALL use one clock, clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-004 A port SHALL request in any cycle where its en_N_x = 0; a grant SHALL be decided combinationally in the same cycle.
REQ-005 With a single requester, that requester SHALL be granted.
REQ-006 When both ports request, port 2 SHALL win if state = LOCKED or starve_cnt = STARVE_LIMIT; otherwise port 1 SHALL win.
REQ-007 busy_N SHALL equal (request_N and not grant_N).
REQ-008 Port-1 grant SHALL drive:
- addr = addr_1, en_x = 0, wr_x = 1, bit_wr_x all ones.
REQ-009 Port-2 grant SHALL drive:
- addr_2, en_x = 0, wr_x = wr_2_x, bit_wr_x = bit_wr_2_x.
REQ-010 With no grant the block SHALL drive:
- en_x = 1, wr_x = 1, bit_wr_x all ones, addr = addr_1.
REQ-011 d SHALL equal d_2 at all times.
REQ-012 The state machine SHALL have two states:
- OPEN to LOCKED when port 2 is granted with lock_2 = 1.
- LOCKED to OPEN at any edge where lock_2 = 0.
REQ-013 In LOCKED, port 1 SHALL be busy whenever it requests, including cycles where port 2 does not request.
REQ-014 starve_cnt SHALL:
- increment, saturating at STARVE_LIMIT, each cycle port 2 requests and is denied;
- clear when port 2 is granted or does not request.
REQ-015 rvalid_1 SHALL be registered as (port-1 granted) in the previous cycle.
REQ-016 rvalid_2 SHALL be registered as (port-2 granted and wr_2_x = 1) in the previous cycle.
REQ-017 q_1 and q_2 SHALL equal q combinationally.

Reset
REQ-018 While rst = 1:
- en_x = 1, wr_x = 1, bit_wr_x all ones;
- busy_1 = busy_2 = 1;
- no grant is issued.
REQ-019 At an edge with rst = 1: state becomes OPEN, starve_cnt = 0, rvalid_1 = rvalid_2 = 0.
REQ-020 Reset asserted mid-burst SHALL abandon the lock; after reset, lock_2 SHALL take effect only through a new port-2 grant.

Configuration
REQ-021 With macro IMEM_ACCESS_SCHED_STARVE_EN defined, starvation promotion per REQ-006 and REQ-014 SHALL be compiled in.
REQ-022 Without IMEM_ACCESS_SCHED_STARVE_EN, starve_cnt SHALL not exist; port 1 SHALL win every conflict except in LOCKED.

Structure
REQ-023 The state encoding (OPEN = 0, LOCKED = 1) and default parameter constants SHALL reside in shared package imem_access_sched_pkg.
REQ-024 The saturating counter SHALL be sub-module imem_starve_cnt (inputs inc, clr; output sat).

Verification
REQ-025 Port 1 only, addr_1 = 0x05, q = 0xDEADBEEF -> en_x = 0, addr = 0x05; next cycle rvalid_1 = 1, q_1 = 0xDEADBEEF.
REQ-026 Both request, STARVE_EN on, STARVE_LIMIT = 4 -> port 1 granted 4 cycles with busy_2 = 1; cycle 5 port 2 granted with busy_1 = 1; counter then clears.
REQ-027 Port-2 write, lock_2 = 1, addr_2 = 0x10, 0x11, 0x12, port 1 requesting throughout -> three writes complete, busy_1 = 1 for all three cycles; lock_2 = 0 -> port 1 granted the next cycle.
REQ-028 Port-2 write, wr_2_x = 0, bit_wr_2_x = 0xFFFF0000 -> wr_x = 0, bit_wr_x = 0xFFFF0000; next cycle rvalid_2 = 0.
REQ-029 rst = 1 during a locked burst -> en_x = 1 immediately; after release, port 1 is granted against port 2 with starve_cnt = 0.
REQ-030 STARVE_EN undefined, both request for 20 cycles -> port 2 is never granted.
